div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             DivCtrl;
  logic             DivDone;
  logic             DivZero;
  logic             DivBusy;
  logic [WIDTH-1:0] HIOut;
  logic [WIDTH-1:0] LOOut;

  modport master (
    output A, B, DivCtrl,
    input  DivDone, DivZero, DivBusy, HIOut, LOOut
  );

  modport slave (
    input  A, B, DivCtrl,
    output DivDone, DivZero, DivBusy, HIOut, LOOut
  );
endinterface

// File: rtl/div_unit.sv
// Signed multi-cycle restoring divider: quotient to LOOut, remainder to HIOut.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  div_unit_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e           r_state;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_quo;
  logic             r_neg_rem;
  logic             r_done;
  logic             r_zero;
  logic             r_busy;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_sub;
  logic             w_fit;

  // Unsigned magnitudes: the most negative value maps onto itself.
  assign w_a_mag  = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
  assign w_b_mag  = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

  // Shifted remainder needs one extra bit; a fitting trial result always fits WIDTH bits.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_fit    = (w_rem_sh >= {1'b0, r_dsr});
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dsr;

  assign bus.DivDone = r_done;
  assign bus.DivZero = r_zero;
  assign bus.DivBusy = r_busy;
  assign bus.HIOut   = r_hi;
  assign bus.LOOut   = r_lo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dsr     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_zero <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.DivCtrl) begin
            if (bus.B == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_zero  <= 1'b1;
            end else begin
              r_quo     <= w_a_mag;
              r_dsr     <= w_b_mag;
              r_rem     <= '0;
              r_cnt     <= '0;
              r_neg_rem <= bus.A[WIDTH-1];
              r_neg_quo <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
              r_busy    <= 1'b1;
              r_state   <= StIter;
            end
          end
        end
        StIter: begin
          r_rem <= w_fit ? w_sub : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fit};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(WIDTH - 1)) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_lo    <= r_neg_quo ? (~r_quo + 1'b1) : r_quo;
          r_hi    <= r_neg_rem ? (~r_rem + 1'b1) : r_rem;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
